// File: rtl/mem_pkg.sv
// Shared memory helpers: byte-lane geometry, address range check and byte-mask merge.
// Sized for words up to 64 bits so cache/AXI memory blocks can reuse them.
package mem_pkg;

   function automatic int unsigned lane_count(input int unsigned data_width);
      return data_width / 8;
   endfunction

   function automatic int unsigned offset_bits(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

   // Operands are zero-extended from the address width, so addr >= base means the subtraction did not wrap.
   function automatic logic addr_in_range(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input logic [63:0] span);
      return (addr >= base) && ((addr - base) < span);
   endfunction

   function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  mask);
      logic [63:0] merged;
      merged = old_word;
      for (int unsigned i = 0; i < 8; i++) begin
         if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response latency pipeline: valid/err/data shift register of depth RD_LATENCY.
// Data only advances alongside valid, so the output word holds between responses.
module mem_rd_pipe #(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic                  in_err,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic                  out_err,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [RD_LATENCY-1:0] valid_q, valid_d;
   logic [RD_LATENCY-1:0] err_q, err_d;
   logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];
   logic [DATA_WIDTH-1:0] data_d [RD_LATENCY];

   always_comb begin
      valid_d[0] = in_valid;
      err_d[0]   = in_valid & in_err;
      data_d[0]  = in_valid ? in_data : data_q[0];
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
         valid_d[i] = valid_q[i-1];
         err_d[i]   = valid_q[i-1] & err_q[i-1];
         data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int unsigned i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         for (int unsigned i = 0; i < RD_LATENCY; i++) data_q[i] <= data_d[i];
      end
   end

   // Outputs are held at zero while reset is asserted, hiding any response still in flight.
   assign out_valid = valid_q[RD_LATENCY-1] & ~reset;
   assign out_err   = err_q[RD_LATENCY-1] & ~reset;
   assign out_data  = reset ? '0 : data_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_dual_sync.sv
// Dual-port synchronous memory: instruction read port plus data read/write port on one word array.
// Byte-masked writes, range checking and write-first forwarding to both read ports.
module mem_dual_sync
   import mem_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           DEPTH_LOG2 = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned           RD_LATENCY = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    pMemInst_pRd_bEn,
   input  logic [ADDR_WIDTH-1:0]   pMemInst_pRd_bAddr,
   output logic                    pMemInst_pRd_bValid,
   output logic [DATA_WIDTH-1:0]   pMemInst_pRd_bData,
   output logic                    pMemInst_pRd_bErr,
   input  logic                    pMemData_pRd_bEn,
   input  logic [ADDR_WIDTH-1:0]   pMemData_pRd_bAddr,
   output logic                    pMemData_pRd_bValid,
   output logic [DATA_WIDTH-1:0]   pMemData_pRd_bData,
   output logic                    pMemData_pRd_bErr,
   input  logic                    pMemData_pWr_bEn,
   input  logic [ADDR_WIDTH-1:0]   pMemData_pWr_bAddr,
   input  logic [DATA_WIDTH-1:0]   pMemData_pWr_bData,
   input  logic [DATA_WIDTH/8-1:0] pMemData_pWr_bMask,
   output logic                    pMemData_pWr_bErr
);

   localparam int unsigned LANES    = lane_count(DATA_WIDTH);
   localparam int unsigned OFF_BITS = offset_bits(DATA_WIDTH);
   localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
   localparam logic [63:0] SPAN     = (64'd1 << DEPTH_LOG2) * 64'(LANES);
   localparam logic [63:0] BASE64   = 64'(BASE_ADDR);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  wr_in_range, wr_commit, wr_err_d, wr_err_q;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic [DATA_WIDTH-1:0] wr_merged;

   logic                  inst_in_range, inst_accept;
   logic [DEPTH_LOG2-1:0] inst_idx;
   logic [DATA_WIDTH-1:0] inst_word;

   logic                  data_in_range, data_accept;
   logic [DEPTH_LOG2-1:0] data_idx;
   logic [DATA_WIDTH-1:0] data_word;

   always_comb begin
      wr_in_range = addr_in_range(64'(pMemData_pWr_bAddr), BASE64, SPAN);
      wr_idx      = DEPTH_LOG2'((pMemData_pWr_bAddr - BASE_ADDR) >> OFF_BITS);
      wr_merged   = DATA_WIDTH'(merge_bytes(64'(mem_q[wr_idx]), 64'(pMemData_pWr_bData),
                                            8'(pMemData_pWr_bMask)));
      // An all-zero mask is neither a commit nor an error, even out of range.
      wr_commit   = pMemData_pWr_bEn & ~reset & wr_in_range & (|pMemData_pWr_bMask);
      wr_err_d    = pMemData_pWr_bEn & ~reset & ~wr_in_range & (|pMemData_pWr_bMask);
   end

   always_comb begin
      inst_in_range = addr_in_range(64'(pMemInst_pRd_bAddr), BASE64, SPAN);
      inst_idx      = DEPTH_LOG2'((pMemInst_pRd_bAddr - BASE_ADDR) >> OFF_BITS);
      inst_accept   = pMemInst_pRd_bEn & ~reset;
      inst_word     = '0;
      if (inst_in_range) inst_word = (wr_commit && inst_idx == wr_idx) ? wr_merged : mem_q[inst_idx];

      data_in_range = addr_in_range(64'(pMemData_pRd_bAddr), BASE64, SPAN);
      data_idx      = DEPTH_LOG2'((pMemData_pRd_bAddr - BASE_ADDR) >> OFF_BITS);
      data_accept   = pMemData_pRd_bEn & ~reset;
      data_word     = '0;
      if (data_in_range) data_word = (wr_commit && data_idx == wr_idx) ? wr_merged : mem_q[data_idx];
   end

   always_ff @(posedge clock) begin
      if (wr_commit) mem_q[wr_idx] <= wr_merged;
   end

   always_ff @(posedge clock) begin
      if (reset) wr_err_q <= 1'b0;
      else       wr_err_q <= wr_err_d;
   end

   assign pMemData_pWr_bErr = wr_err_q;

   mem_rd_pipe #(
      .RD_LATENCY (RD_LATENCY),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_inst_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (inst_accept),
      .in_err    (~inst_in_range),
      .in_data   (inst_word),
      .out_valid (pMemInst_pRd_bValid),
      .out_err   (pMemInst_pRd_bErr),
      .out_data  (pMemInst_pRd_bData)
   );

   mem_rd_pipe #(
      .RD_LATENCY (RD_LATENCY),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_data_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (data_accept),
      .in_err    (~data_in_range),
      .in_data   (data_word),
      .out_valid (pMemData_pRd_bValid),
      .out_err   (pMemData_pRd_bErr),
      .out_data  (pMemData_pRd_bData)
   );

endmodule

// File: tb/tb_mem_dual_sync.sv
// Directed bench for mem_dual_sync: one latency-1 and one latency-3 instance share the stimulus.
module tb_mem_dual_sync;

   logic        clock = 1'b0;
   logic        reset;
   logic        i_en, d_en, wr_en;
   logic [31:0] i_addr, d_addr, wr_addr, wr_data;
   logic [3:0]  wr_mask;

   logic        i_valid, i_err, d_valid, d_err, wr_err;
   logic [31:0] i_data, d_data;
   logic        i3_valid, i3_err, d3_valid, d3_err, wr3_err;
   logic [31:0] i3_data, d3_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   mem_dual_sync u_dut (
      .clock               (clock),
      .reset               (reset),
      .pMemInst_pRd_bEn    (i_en),
      .pMemInst_pRd_bAddr  (i_addr),
      .pMemInst_pRd_bValid (i_valid),
      .pMemInst_pRd_bData  (i_data),
      .pMemInst_pRd_bErr   (i_err),
      .pMemData_pRd_bEn    (d_en),
      .pMemData_pRd_bAddr  (d_addr),
      .pMemData_pRd_bValid (d_valid),
      .pMemData_pRd_bData  (d_data),
      .pMemData_pRd_bErr   (d_err),
      .pMemData_pWr_bEn    (wr_en),
      .pMemData_pWr_bAddr  (wr_addr),
      .pMemData_pWr_bData  (wr_data),
      .pMemData_pWr_bMask  (wr_mask),
      .pMemData_pWr_bErr   (wr_err)
   );

   mem_dual_sync #(.RD_LATENCY(3)) u_dut3 (
      .clock               (clock),
      .reset               (reset),
      .pMemInst_pRd_bEn    (i_en),
      .pMemInst_pRd_bAddr  (i_addr),
      .pMemInst_pRd_bValid (i3_valid),
      .pMemInst_pRd_bData  (i3_data),
      .pMemInst_pRd_bErr   (i3_err),
      .pMemData_pRd_bEn    (d_en),
      .pMemData_pRd_bAddr  (d_addr),
      .pMemData_pRd_bValid (d3_valid),
      .pMemData_pRd_bData  (d3_data),
      .pMemData_pRd_bErr   (d3_err),
      .pMemData_pWr_bEn    (wr_en),
      .pMemData_pWr_bAddr  (wr_addr),
      .pMemData_pWr_bData  (wr_data),
      .pMemData_pWr_bMask  (wr_mask),
      .pMemData_pWr_bErr   (wr3_err)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      i_en  = 1'b0;
      d_en  = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic write_word(input logic [31:0] a, input logic [31:0] v, input logic [3:0] m);
      wr_en = 1'b1; wr_addr = a; wr_data = v; wr_mask = m;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic data_read(input logic [31:0] a);
      d_en = 1'b1; d_addr = a;
      tick();
      d_en = 1'b0;
   endtask

   initial begin
      idle();
      i_addr = '0; d_addr = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
      reset = 1'b1;
      tick();
      tick();
      check_eq("rst_ivalid", i_valid, 0);
      check_eq("rst_idata",  i_data,  0);
      check_eq("rst_dvalid", d_valid, 0);
      check_eq("rst_ddata",  d_data,  0);
      check_eq("rst_derr",   d_err,   0);
      check_eq("rst_wrerr",  wr_err,  0);
      check_eq("rst_i3valid", i3_valid, 0);
      reset = 1'b0;

      write_word(32'h8000_0000, 32'hA5A5_A5A5, 4'hF);
      write_word(32'h8000_3FFC, 32'h0BAD_F00D, 4'hF);
      for (int i = 0; i < 8; i++) write_word(32'h8000_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF);
      tick(); tick(); tick();

      // Request, then reset the very next cycle: no response may appear on either instance.
      i_en = 1'b1; i_addr = 32'h8000_0000;
      tick();
      i_en = 1'b0;
      reset = 1'b1;
      #1;
      check_eq("midrst_ivalid", i_valid, 0);
      tick();
      check_eq("midrst_idata", i_data, 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("midrst_ivalid_after", i_valid, 0);
         check_eq("midrst_i3valid", i3_valid, 0);
      end

      write_word(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
      check_eq("fullwr_wrerr", wr_err, 0);
      data_read(32'h8000_0010);
      check_eq("fullwr_dvalid", d_valid, 1);
      check_eq("fullwr_ddata",  d_data,  32'hDEAD_BEEF);
      check_eq("fullwr_derr",   d_err,   0);
      check_eq("fullwr_d3early", d3_valid, 0);
      tick();
      check_eq("fullwr_dvalid_once", d_valid, 0);
      tick();
      check_eq("lat3_dvalid", d3_valid, 1);
      check_eq("lat3_ddata",  d3_data,  32'hDEAD_BEEF);

      write_word(32'h8000_0014, 32'h1122_3344, 4'hF);
      write_word(32'h8000_0014, 32'h0000_AA00, 4'b0010);
      data_read(32'h8000_0014);
      check_eq("bytewr_ddata", d_data, 32'h1122_AA44);

      write_word(32'h8000_0018, 32'h1234_5678, 4'hF);
      wr_en = 1'b1; wr_addr = 32'h8000_0018; wr_data = 32'h0000_00FF; wr_mask = 4'b0001;
      i_en  = 1'b1; i_addr  = 32'h8000_0018;
      d_en  = 1'b1; d_addr  = 32'h8000_0018;
      tick();
      idle();
      check_eq("fwd_ivalid", i_valid, 1);
      check_eq("fwd_idata",  i_data,  32'h1234_56FF);
      check_eq("fwd_ddata",  d_data,  32'h1234_56FF);
      tick();
      check_eq("hold_dvalid", d_valid, 0);
      check_eq("hold_ddata",  d_data,  32'h1234_56FF);
      data_read(32'h8000_0018);
      check_eq("after_wr_ddata", d_data, 32'h1234_56FF);

      data_read(32'h7FFF_FFFC);
      check_eq("oor_rd_dvalid", d_valid, 1);
      check_eq("oor_rd_derr",   d_err,   1);
      check_eq("oor_rd_ddata",  d_data,  0);

      write_word(32'h8000_4000, 32'hFFFF_FFFF, 4'hF);
      check_eq("oor_wr_err", wr_err, 1);
      tick();
      check_eq("oor_wr_err_pulse", wr_err, 0);
      data_read(32'h8000_0000);
      check_eq("oor_wr_untouched", d_data, 32'hA5A5_A5A5);
      check_eq("word0_derr", d_err, 0);

      i_en = 1'b1; i_addr = 32'h8000_3FFC;
      tick();
      i_en = 1'b0;
      check_eq("top_word_idata", i_data, 32'h0BAD_F00D);
      check_eq("top_word_ierr",  i_err,  0);
      data_read(32'h8000_0013);
      check_eq("unaligned_ddata", d_data, 32'hDEAD_BEEF);
      tick(); tick(); tick();

      for (int k = 0; k < 11; k++) begin
         i_en   = (k < 8);
         i_addr = 32'h8000_0100 + 32'(4 * k);
         tick();
         check_eq("burst3_valid", i3_valid, (k >= 2 && k < 10) ? 1 : 0);
         if (k >= 2 && k < 10) check_eq("burst3_data", i3_data, 32'hC0DE_0000 + 32'(k - 2));
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
